// File: rtl/surface_normal_sequencer.sv
// surface_normal_sequencer
//   Estimates the surface normal at a hit point by central differences. The
//   six probe positions p +/- EPS along x, y and z go one at a time to a shared
//   SDF unit. The unnormalised gradient is returned together with the vector
//   from the hit point to the light.
//
// Ports
//   clk, rst                   : rising-edge clock, asynchronous active-high reset
//   start_valid / start_ready  : request handshake, p and light_pos sampled on it
//   p, light_pos               : vec3 {x,y,z}, each signed Q8.24
//   sdf_req_valid / _ready     : probe query handshake, position on sdf_req_pos
//   sdf_resp_valid / _dist     : one distance pulse per accepted query
//   out_valid / out_ready      : result handshake for grad and light_vec
//   busy                       : high whenever the sequencer is not idle
module surface_normal_sequencer #(
   parameter logic signed [31:0] EPS = 32'sh00004189
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [95:0]        p,
   input  logic [95:0]        light_pos,
   output logic               sdf_req_valid,
   input  logic               sdf_req_ready,
   output logic [95:0]        sdf_req_pos,
   input  logic               sdf_resp_valid,
   input  logic signed [31:0] sdf_resp_dist,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [95:0]        grad,
   output logic [95:0]        light_vec,
   output logic               busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [2:0]         q_q, q_d;
   logic [95:0]        p_q, p_d;
   logic [95:0]        light_vec_q, light_vec_d;
   logic [95:0]        grad_q, grad_d;
   logic signed [31:0] d_plus_q, d_plus_d;

   logic signed [31:0] qx, qy, qz;
   logic signed [31:0] diff;

   // Plain two's complement; overflow wraps silently.
   function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
      return a + b;
   endfunction

   function automatic logic signed [31:0] wrap_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
      return a - b;
   endfunction

   // Even query index probes +EPS, odd probes -EPS; q>>1 selects the axis.
   always_comb begin
      qx = $signed(p_q[95:64]);
      qy = $signed(p_q[63:32]);
      qz = $signed(p_q[31:0]);
      case (q_q[2:1])
         2'd0:    qx = q_q[0] ? wrap_sub(qx, EPS) : wrap_add(qx, EPS);
         2'd1:    qy = q_q[0] ? wrap_sub(qy, EPS) : wrap_add(qy, EPS);
         default: qz = q_q[0] ? wrap_sub(qz, EPS) : wrap_add(qz, EPS);
      endcase
   end

   assign diff = wrap_sub(d_plus_q, sdf_resp_dist);

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      p_d         = p_q;
      light_vec_d = light_vec_q;
      grad_d      = grad_q;
      d_plus_d    = d_plus_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               p_d         = p;
               light_vec_d = {wrap_sub($signed(light_pos[95:64]), $signed(p[95:64])),
                              wrap_sub($signed(light_pos[63:32]), $signed(p[63:32])),
                              wrap_sub($signed(light_pos[31:0]),  $signed(p[31:0]))};
               q_d         = 3'd0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // A response arriving here is stale or spurious and is dropped.
            if (sdf_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sdf_resp_valid) begin
               if (!q_q[0]) begin
                  d_plus_d = sdf_resp_dist;
               end else begin
                  case (q_q[2:1])
                     2'd0:    grad_d[95:64] = diff;
                     2'd1:    grad_d[63:32] = diff;
                     default: grad_d[31:0]  = diff;
                  endcase
               end
               q_d     = q_q + 3'd1;
               state_d = (q_q < 3'd5) ? S_ISSUE : S_DONE;
            end
         end
         default: begin
            if (out_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         q_q         <= 3'd0;
         p_q         <= '0;
         light_vec_q <= '0;
         grad_q      <= '0;
         d_plus_q    <= '0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         p_q         <= p_d;
         light_vec_q <= light_vec_d;
         grad_q      <= grad_d;
         d_plus_q    <= d_plus_d;
      end
   end

   assign start_ready   = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign sdf_req_valid = (state_q == S_ISSUE);
   assign out_valid     = (state_q == S_DONE);
   assign sdf_req_pos   = (state_q == S_ISSUE) ? {qx, qy, qz} : 96'd0;
   assign grad          = grad_q;
   assign light_vec     = light_vec_q;

endmodule

// File: tb/tb_surface_normal_sequencer.sv
// Bench for surface_normal_sequencer: a behavioural SDF responder plus a
// reference model of probe positions, gradient and light vector.
module tb_surface_normal_sequencer;

   localparam logic [31:0] EPS = 32'h00004189;

   logic        clk = 1'b0;
   logic        rst, start_valid, start_ready;
   logic [95:0] p, light_pos;
   logic        sdf_req_valid, sdf_req_ready;
   logic [95:0] sdf_req_pos;
   logic        sdf_resp_valid;
   logic [31:0] sdf_resp_dist;
   logic        out_valid, out_ready;
   logic [95:0] grad, light_vec;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int          sdf_sel = 0;
   int          stall_n = 0;
   bit          spur_issue = 0;
   bit          spur_once = 0;
   logic [95:0] qlog[$];

   logic [95:0] mp, exp_grad, exp_lv;
   int          mq = 0;
   logic [95:0] got_grad, got_lv;

   always #5 clk = ~clk;

   surface_normal_sequencer #(.EPS(32'sh00004189)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .p(p), .light_pos(light_pos),
      .sdf_req_valid(sdf_req_valid), .sdf_req_ready(sdf_req_ready),
      .sdf_req_pos(sdf_req_pos),
      .sdf_resp_valid(sdf_resp_valid), .sdf_resp_dist(sdf_resp_dist),
      .out_valid(out_valid), .out_ready(out_ready),
      .grad(grad), .light_vec(light_vec), .busy(busy)
   );

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Scene SDFs: 0 = plane d=x, 1 = d = x + 3y - z (all 32-bit wrapping).
   function automatic logic [31:0] sdf(input logic [95:0] pos);
      logic [31:0] x, y, z;
      x = pos[95:64]; y = pos[63:32]; z = pos[31:0];
      if (sdf_sel == 1) return x + 32'd3 * y - z;
      return x;
   endfunction

   function automatic logic [95:0] qpos(input logic [95:0] pp, input int k);
      logic [31:0] c[3];
      c[0] = pp[95:64]; c[1] = pp[63:32]; c[2] = pp[31:0];
      if (k >= 0 && k < 6) begin
         if (k % 2 == 0) c[k/2] = c[k/2] + EPS;
         else            c[k/2] = c[k/2] - EPS;
      end
      return {c[0], c[1], c[2]};
   endfunction

   function automatic logic [95:0] model_grad(input logic [95:0] pp);
      logic [31:0] g[3];
      for (int i = 0; i < 3; i++) g[i] = sdf(qpos(pp, 2*i)) - sdf(qpos(pp, 2*i + 1));
      return {g[0], g[1], g[2]};
   endfunction

   function automatic logic [95:0] model_lv(input logic [95:0] pp, input logic [95:0] lp);
      return {lp[95:64] - pp[95:64], lp[63:32] - pp[63:32], lp[31:0] - pp[31:0]};
   endfunction

   // SDF unit: holds ready low stall_n cycles per query, answers one cycle
   // after acceptance, optionally injects spurious responses.
   initial begin
      int          vc;
      logic        hs;
      logic [95:0] hpos;
      vc = 0;
      sdf_req_ready = 1'b0; sdf_resp_valid = 1'b0; sdf_resp_dist = '0;
      forever begin
         @(negedge clk);
         hs   = sdf_req_valid && sdf_req_ready && !rst;
         hpos = sdf_req_pos;
         if (rst || hs) vc = 0;
         else if (sdf_req_valid && !sdf_req_ready) vc++;
         if (hs) qlog.push_back(hpos);
         @(posedge clk); #1;
         sdf_resp_valid = 1'b0;
         sdf_resp_dist  = 32'hDEADBEEF;
         if (hs) begin
            sdf_resp_valid = 1'b1;
            sdf_resp_dist  = sdf(hpos);
         end else if ((spur_issue && sdf_req_valid) || spur_once) begin
            sdf_resp_valid = 1'b1;
            spur_once = 1'b0;
         end
         sdf_req_ready = sdf_req_valid && (vc >= stall_n);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (sdf_req_valid) chk("req_pos", sdf_req_pos, qpos(mp, mq));
         if (sdf_req_valid && sdf_req_ready) mq++;
         if (out_valid) begin
            chk("grad", grad, exp_grad);
            chk("light_vec", light_vec, exp_lv);
            chk("nqueries", 96'(mq), 96'd6);
         end
         if (start_valid && start_ready) begin
            mp       = p;
            mq       = 0;
            exp_grad = model_grad(p);
            exp_lv   = model_lv(p, light_pos);
         end
      end
   end

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      got_grad = grad;
      got_lv   = light_vec;
   endtask

   task automatic start_and_wait(input logic [95:0] pp, input logic [95:0] lp,
                                 input int stall, output int lat);
      qlog.delete();
      stall_n = stall;
      chk("start_ready_idle", 96'(start_ready), 96'd1);
      p = pp; light_pos = lp; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      wait_out(lat);
   endtask

   task automatic accept_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_after_out", 96'({start_ready, out_valid, busy}), 96'b100);
      chk("grad_retained", grad, got_grad);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   localparam logic [95:0] P1 = {32'h01000000, 32'h02000000, 32'h03000000};
   localparam logic [95:0] G1 = {32'h00008312, 32'h0, 32'h0};

   initial begin
      int lat, hc, cyc;
      rst = 1'b1; start_valid = 1'b0; out_ready = 1'b0; p = '0; light_pos = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", 96'({out_valid, sdf_req_valid, busy, start_ready}), 96'b0001);
      chk("rst_data", {grad ^ light_vec, sdf_req_pos} == '0 ? 96'd0 : 96'd1, 96'd0);
      chk("rst_grad", grad, 96'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Plane SDF, no back-pressure.
      start_and_wait(P1, 96'd0, 0, lat);
      chk("lat_plane", 96'(lat), 96'd12);
      chk("grad_plane_lit", got_grad, G1);
      chk("lv_plane_lit", got_lv, {32'hFF000000, 32'hFE000000, 32'hFD000000});
      accept_out();

      // Request back-pressure of 5 cycles on every query.
      start_and_wait(P1, 96'd0, 5, lat);
      chk("lat_stall", 96'(lat), 96'd42);
      chk("grad_stall_lit", got_grad, G1);
      accept_out();

      // Output back-pressure; start held high through DONE must be ignored.
      start_and_wait({32'h00400000, 32'h00000000, 32'hFF000000}, P1, 0, lat);
      chk("lat_hold", 96'(lat), 96'd12);
      p = {32'h00000100, 32'h00000200, 32'h00000300}; light_pos = 96'd0;
      start_valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("hold_start_ready", 96'(start_ready), 96'd0);
         chk("hold_grad", grad, got_grad);
         chk("hold_lv", light_vec, got_lv);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("gap_idle", 96'({start_ready, out_valid}), 96'b10);
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk("next_accepted", 96'(busy), 96'd1);
      wait_out(lat);
      chk("lat_chain", 96'(lat), 96'd12);
      accept_out();

      // Second scene with moderate stall.
      sdf_sel = 1;
      start_and_wait({32'h00800000, 32'hFF400000, 32'h12345678},
                     {32'h10000000, 32'h00000000, 32'h01000000}, 2, lat);
      chk("lat_scene1", 96'(lat), 96'd24);
      chk("grad_scene1_lit", got_grad, {32'h00008312, 32'h00018936, 32'hFFFF7CEE});
      chk("lv_scene1_lit", got_lv, {32'h0F800000, 32'h00C00000, 32'hEECBA988});
      accept_out();

      // Wrapping probe positions and spurious responses during ISSUE.
      sdf_sel = 0; spur_issue = 1'b1;
      start_and_wait({32'h7FFFFFF0, 32'h0, 32'h0}, 96'd0, 3, lat);
      spur_issue = 1'b0;
      chk("lat_spur", 96'(lat), 96'd30);
      chk("wrap_q0_lit", 96'(qlog[0][95:64]), 96'h80004179);
      chk("wrap_q1_lit", 96'(qlog[1][95:64]), 96'h7FFFBE67);
      chk("grad_wrap_lit", got_grad, G1);
      accept_out();

      // Reset in WAIT at q=3, then a stale response.
      stall_n = 0;
      p = P1; light_pos = 96'd0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      hc = 0; cyc = 0;
      while (hc < 4 && cyc < 100) begin
         @(negedge clk);
         if (sdf_req_valid && sdf_req_ready) hc++;
         cyc++;
      end
      chk("reach_q3", 96'(hc), 96'd4);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_ctrl", 96'({out_valid, sdf_req_valid, busy, start_ready}), 96'b0001);
         chk("midrst_grad", grad, 96'd0);
         chk("midrst_lv", light_vec, 96'd0);
         chk("midrst_pos", sdf_req_pos, 96'd0);
      end
      rst = 1'b0; spur_once = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stale_ignored", 96'({busy, start_ready, sdf_req_valid}), 96'b010);
      end
      start_and_wait({32'h00400000, 32'hFFC00000, 32'h00000010},
                     {32'h01000000, 32'h01000000, 32'h01000000}, 0, lat);
      chk("lat_after_rst", 96'(lat), 96'd12);
      chk("lv_after_rst_lit", got_lv, {32'h00C00000, 32'h01400000, 32'h00FFFFF0});
      chk("grad_after_rst_lit", got_grad, G1);
      accept_out();

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/surface_normal_sequencer.md
SURFACE_NORMAL_SEQUENCER -- requirements
Module: surface_normal_sequencer

Interface
REQ-001 SHALL have parameter EPS, fp, default 32'h00004189, meaning normal-probe offset (0.001 in signed Q8.24).
REQ-002 SHALL have ports as follows, clock and reset first; vec3 is 96 bits packed {x[95:64], y[63:32], z[31:0]}, each a signed Q8.24 fp:
clk  input  1  sole clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  request a surface evaluation.
start_ready  output  1  sequencer idle and able to accept a request.
p  input  96  hit point, sampled on start handshake.
light_pos  input  96  light position, sampled on start handshake.
sdf_req_valid  output  1  SDF query valid.
sdf_req_ready  input  1  shared SDF unit accepts the query.
sdf_req_pos  output  96  query position.
sdf_resp_valid  input  1  SDF distance valid, one pulse per accepted query.
sdf_resp_dist  input  32  signed Q8.24 distance.
out_valid  output  1  results valid.
out_ready  input  1  consumer accepts results.
grad  output  96  unnormalised gradient, central differences.
light_vec  output  96  light_pos minus p.
busy  output  1  high in any state except IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; start_ready SHALL equal (state==IDLE).
REQ-004 On start_valid&&start_ready, SHALL register p, register light_vec = light_pos - p per component, clear query index q to 0, and go to ISSUE.
REQ-005 Query order for q=0..5 SHALL be p+(EPS,0,0), p-(EPS,0,0), p+(0,EPS,0), p-(0,EPS,0), p+(0,0,EPS), p-(0,0,EPS).
REQ-006 In ISSUE, sdf_req_valid SHALL be 1 and sdf_req_pos SHALL hold query q; both SHALL stay stable until sdf_req_ready; on handshake the FSM SHALL go to WAIT.
REQ-007 At most one query SHALL be outstanding; sdf_req_valid SHALL be 0 outside ISSUE.
REQ-008 In WAIT, sdf_resp_valid SHALL be consumed: even q stores d_plus; odd q writes grad component (q>>1) = d_plus - sdf_resp_dist.
REQ-009 After consuming a response, SHALL increment q and go to ISSUE if q<5, else to DONE.
REQ-010 sdf_resp_valid SHALL be ignored in IDLE, ISSUE and DONE, including a response in the same cycle as the request handshake.
REQ-011 In DONE, out_valid SHALL be 1, and grad and light_vec SHALL be held stable until out_ready; on handshake the FSM SHALL go to IDLE.
REQ-012 grad and light_vec SHALL retain their last values in IDLE until the next result is written.
REQ-013 All additions and subtractions SHALL be 32-bit two's complement, wrapping modulo 2^32 with no saturation or overflow flag.
REQ-014 Latency SHALL be fixed: with sdf_req_ready=1 and a response one cycle after each acceptance, out_valid SHALL rise 12 cycles after the start handshake edge.
REQ-015 Back-pressure on sdf_req_ready or out_ready SHALL only stall; no query SHALL be skipped, repeated or reordered.
REQ-016 The start handshake SHALL NOT occur in DONE in the same cycle as the out handshake, so the minimum gap is one IDLE cycle.

Reset
REQ-017 While rst=1, state SHALL be IDLE, q=0, and every output SHALL be 0 (grad, light_vec, sdf_req_pos, out_valid, sdf_req_valid, busy), except start_ready, which SHALL be 1.
REQ-018 Reset asserted mid-operation SHALL abandon the evaluation; a stale sdf_resp_valid arriving after reset release SHALL be ignored per REQ-010.

Verification
REQ-019 Plane SDF d=x, p=(1.0,2.0,3.0)=(0x01000000,0x02000000,0x03000000), light_pos=0 -> grad=(0x00008312,0,0), light_vec=(0xFF000000,0xFE000000,0xFD000000), out_valid exactly 12 cycles after start.
REQ-020 sdf_req_ready held low 5 cycles on every query -> sdf_req_pos stable throughout, six queries in REQ-005 order, same grad values, out_valid at cycle 42.
REQ-021 out_ready low 10 cycles in DONE -> outputs stable, start_ready=0, start_valid ignored; one IDLE cycle after the handshake, then the next start is accepted.
REQ-022 rst pulsed during WAIT at q=3, followed by a stale sdf_resp_valid -> all outputs 0, state IDLE, response ignored; the next full evaluation is correct.
REQ-023 p.x=0x7FFFFFF0 -> query 0 sdf_req_pos.x=0x80004179 (wrap), query 1 = 0x7FFFBE67; spurious sdf_resp_valid in ISSUE -> no state change.
